// File: rtl/hci_mem_resp_tracker_pkg.sv
// Shared types and constants for the per-bank response tracker.
// The test-and-set FSM encoding and the lock pattern live here.
package hci_mem_resp_tracker_pkg;

    typedef enum logic {
        TS_IDLE  = 1'b0,
        TS_WRITE = 1'b1
    } hci_ts_state_e;

    localparam int HCI_MAX_DW      = 1024;
    localparam int HCI_MEM_LAT_MIN = 1;
    localparam int HCI_MEM_LAT_MAX = 4;

    // The lock pattern. Banks take the low DW bits.
    localparam logic [HCI_MAX_DW-1:0] HCI_TS_WDATA_ONES = '1;

endpackage

// File: rtl/hci_mem_resp_tracker_bank.sv
// One bank: test-and-set FSM, locked-address latch and a MEM_LAT-deep valid/ID pipeline.
// Handshake: accept = req_i & mem_gnt_i in TS_IDLE; responses are never back-pressured.
module hci_mem_resp_tracker_bank
    import hci_mem_resp_tracker_pkg::*;
#(
    parameter int IW      = 20,
    parameter int DW      = 32,
    parameter int AWM     = 32,
    parameter int MEM_LAT = 1,
    parameter bit TS_EN   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [AWM-1:0]    add_i,
    input  logic              wen_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [DW/8-1:0]   be_i,
    input  logic [IW-1:0]     id_i,
    input  logic              ts_set_i,
    output logic              gnt_o,
    output logic              r_valid_o,
    output logic [IW-1:0]     r_id_o,
    output logic [DW-1:0]     r_data_o,
    output logic              mem_req_o,
    output logic              mem_wen_o,
    output logic [AWM-1:0]    mem_add_o,
    output logic [DW-1:0]     mem_wdata_o,
    output logic [DW/8-1:0]   mem_be_o,
    input  logic              mem_gnt_i,
    input  logic [DW-1:0]     mem_r_data_i,
    output logic              ts_state_o
);

    hci_ts_state_e     r_state;
    hci_ts_state_e     w_state_nxt;
    logic [AWM-1:0]    r_ts_add;
    logic              w_accept;
    logic              w_ts_trigger;
    logic [MEM_LAT-1:0] r_vld_pipe;
    logic [IW-1:0]     r_id_pipe [MEM_LAT];

    always_comb begin
        w_state_nxt  = r_state;
        mem_req_o    = req_i;
        mem_wen_o    = wen_i;
        mem_add_o    = add_i;
        mem_wdata_o  = wdata_i;
        mem_be_o     = be_i;
        gnt_o        = mem_gnt_i;
        w_accept     = req_i & mem_gnt_i;
        w_ts_trigger = 1'b0;
        case (r_state)
            TS_IDLE: begin
                w_ts_trigger = w_accept & TS_EN & ts_set_i & wen_i;
                if (w_ts_trigger) w_state_nxt = TS_WRITE;
            end
            TS_WRITE: begin
                // The bank is owned by the lock write; crossbar traffic waits.
                mem_req_o   = 1'b1;
                mem_wen_o   = 1'b0;
                mem_add_o   = r_ts_add;
                mem_wdata_o = HCI_TS_WDATA_ONES[DW-1:0];
                mem_be_o    = '1;
                gnt_o       = 1'b0;
                w_accept    = 1'b0;
                if (mem_gnt_i) w_state_nxt = TS_IDLE;
            end
            default: w_state_nxt = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= TS_IDLE;
            r_ts_add <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ts_trigger) r_ts_add <= add_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_id_pipe[i] <= '0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            r_id_pipe[0]  <= w_accept ? id_i : '0;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_id_pipe[i]  <= r_id_pipe[i-1];
            end
        end
    end

    assign r_valid_o  = r_vld_pipe[MEM_LAT-1];
    assign r_id_o     = r_id_pipe[MEM_LAT-1];
    assign r_data_o   = r_valid_o ? mem_r_data_i : '0;
    assign ts_state_o = (r_state == TS_WRITE);

endmodule

// File: rtl/hci_mem_resp_tracker.sv
// N_MEM independent bank trackers; this level only slices the flattened bank vectors.
// ts_state_o exposes each bank's FSM (1 = TS_WRITE).
module hci_mem_resp_tracker
    import hci_mem_resp_tracker_pkg::*;
#(
    parameter int N_MEM   = 32,
    parameter int IW      = 20,
    parameter int DW      = 32,
    parameter int AWM     = 32,
    parameter int MEM_LAT = 1,
    parameter bit TS_EN   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_MEM-1:0]        req_i,
    input  logic [N_MEM*AWM-1:0]    add_i,
    input  logic [N_MEM-1:0]        wen_i,
    input  logic [N_MEM*DW-1:0]     wdata_i,
    input  logic [N_MEM*DW/8-1:0]   be_i,
    input  logic [N_MEM*IW-1:0]     id_i,
    input  logic [N_MEM-1:0]        ts_set_i,
    output logic [N_MEM-1:0]        gnt_o,
    output logic [N_MEM-1:0]        r_valid_o,
    output logic [N_MEM*IW-1:0]     r_id_o,
    output logic [N_MEM*DW-1:0]     r_data_o,
    output logic [N_MEM-1:0]        mem_req_o,
    output logic [N_MEM-1:0]        mem_wen_o,
    output logic [N_MEM*AWM-1:0]    mem_add_o,
    output logic [N_MEM*DW-1:0]     mem_wdata_o,
    output logic [N_MEM*DW/8-1:0]   mem_be_o,
    input  logic [N_MEM-1:0]        mem_gnt_i,
    input  logic [N_MEM*DW-1:0]     mem_r_data_i,
    output logic [N_MEM-1:0]        ts_state_o
);

    localparam int BW = DW / 8;

    if (MEM_LAT < HCI_MEM_LAT_MIN || MEM_LAT > HCI_MEM_LAT_MAX) begin : g_lat_check
        $error("hci_mem_resp_tracker: MEM_LAT must be within 1..4");
    end

    for (genvar b = 0; b < N_MEM; b++) begin : g_bank
        hci_mem_resp_tracker_bank #(
            .IW      (IW),
            .DW      (DW),
            .AWM     (AWM),
            .MEM_LAT (MEM_LAT),
            .TS_EN   (TS_EN)
        ) u_bank (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .req_i        (req_i[b]),
            .add_i        (add_i[b*AWM +: AWM]),
            .wen_i        (wen_i[b]),
            .wdata_i      (wdata_i[b*DW +: DW]),
            .be_i         (be_i[b*BW +: BW]),
            .id_i         (id_i[b*IW +: IW]),
            .ts_set_i     (ts_set_i[b]),
            .gnt_o        (gnt_o[b]),
            .r_valid_o    (r_valid_o[b]),
            .r_id_o       (r_id_o[b*IW +: IW]),
            .r_data_o     (r_data_o[b*DW +: DW]),
            .mem_req_o    (mem_req_o[b]),
            .mem_wen_o    (mem_wen_o[b]),
            .mem_add_o    (mem_add_o[b*AWM +: AWM]),
            .mem_wdata_o  (mem_wdata_o[b*DW +: DW]),
            .mem_be_o     (mem_be_o[b*BW +: BW]),
            .mem_gnt_i    (mem_gnt_i[b]),
            .mem_r_data_i (mem_r_data_i[b*DW +: DW]),
            .ts_state_o   (ts_state_o[b])
        );
    end

endmodule
